sonic_rx_dma_fetch: RTL and testbench

Read-side consumer of the SFP rx circular buffer. It watches the buffer's qword write pointer and waits until a full DMA block of `rx_block_size` qwords is available. It then drives `rd_req` / `rd_address_owords` to pull that block out as 128-bit owords and presents them on a valid/ready stream framed with sop/eop. The stream feeds the PCIe DMA write/descriptor stage, and the block reports the committed ring read pointer back to the irq/prg_reg logic.

---
 rtl/sonic_rx_dma_fetch.sv | 179 +++++++++++++++++
 tb/tb_sonic_rx_dma_fetch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_rx_dma_fetch.sv
// Read-side DMA block fetcher for the SFP rx ring: waits for a full block, reads it as owords
// and streams it out with sop/eop framing. Optional SONIC_RX_FETCH_OVERRUN_EN enables the lap flag.
//
// state   | meaning
// S_IDLE  | waiting for a full block in the ring (or disabled)
// S_FETCH | issuing oword reads for the current block, credit-limited by the skid FIFO
module sonic_rx_dma_fetch #(
  parameter int USED_QWORDS_WIDTH = 16,
  parameter int RD_LATENCY        = 2,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                           clk_in,
  input  logic                           rstn,
  input  logic                           enable_sfp,
  input  logic [USED_QWORDS_WIDTH-1:0]   rx_ring_wptr,
  input  logic [31:0]                    rx_block_size,
  output logic                           rd_req,
  output logic [USED_QWORDS_WIDTH-2:0]   rd_address_owords,
  input  logic [127:0]                   rd_data,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [127:0]                   dout_data,
  output logic                           dout_sop,
  output logic                           dout_eop,
  output logic [USED_QWORDS_WIDTH-1:0]   rx_ring_rptr,
  output logic [31:0]                    blocks_done,
  output logic                           overrun
);
  localparam int W  = USED_QWORDS_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t                r_state;
  logic [W-2:0]          r_issue_ow;
  logic [W-1:0]          r_remaining;
  logic                  r_first;
  logic [RD_LATENCY-1:0] r_sr_v, r_sr_sop, r_sr_eop;
  logic [129:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_fifo_cnt, r_inflight;
  logic [W-1:0]          r_rptr;
  logic [31:0]           r_blocks;

  logic [W-1:0]          w_bs_ow;
  logic [W-1:0]          w_avail;
  logic                  w_start, w_credit, w_issue, w_ret, w_pop;
  logic [129:0]          w_head;
  logic                  w_unused_bits;

  assign w_bs_ow       = rx_block_size[W:1];
  assign w_unused_bits = ^{rx_block_size[31:W+1], rx_block_size[0]};
  assign w_avail       = rx_ring_wptr - {r_issue_ow, 1'b0};
  assign w_start       = enable_sfp && (w_bs_ow != '0) && ({1'b0, w_avail} >= {w_bs_ow, 1'b0});
  // Credit counts every oword that could still land in the FIFO, so returns never overflow it.
  assign w_credit      = ({1'b0, r_inflight} + {1'b0, r_fifo_cnt}) < CW'(FIFO_DEPTH);
  assign w_issue       = enable_sfp && (r_state == S_FETCH) && w_credit;
  assign w_ret         = r_sr_v[RD_LATENCY-1];
  assign w_pop         = dout_valid && dout_ready;
  assign w_head        = r_mem[r_rd_ptr];

  assign rd_req            = w_issue;
  assign rd_address_owords = r_issue_ow;
  assign dout_valid        = (r_fifo_cnt != '0);
  assign dout_data         = dout_valid ? w_head[127:0] : '0;
  assign dout_sop          = dout_valid & w_head[129];
  assign dout_eop          = dout_valid & w_head[128];
  assign rx_ring_rptr      = r_rptr;
  assign blocks_done       = r_blocks;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_issue_ow  <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
    end else if (!enable_sfp) begin
      r_state     <= S_IDLE;
      r_issue_ow  <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_FETCH;
            r_remaining <= w_bs_ow;
            r_first     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_issue_ow  <= r_issue_ow + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            r_first     <= 1'b0;
            if (r_remaining == W'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Return tags ride a shift register aligned with the ring's read latency.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_sr_v     <= '0;
      r_sr_sop   <= '0;
      r_sr_eop   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_inflight <= '0;
    end else if (!enable_sfp) begin
      r_sr_v     <= '0;
      r_sr_sop   <= '0;
      r_sr_eop   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_inflight <= '0;
    end else begin
      r_sr_v[0]   <= w_issue;
      r_sr_sop[0] <= w_issue & r_first;
      r_sr_eop[0] <= w_issue & (r_remaining == W'(1));
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_sr_v[i]   <= r_sr_v[i-1];
        r_sr_sop[i] <= r_sr_sop[i-1];
        r_sr_eop[i] <= r_sr_eop[i-1];
      end
      if (w_ret) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_ret, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      case ({w_issue, w_ret})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_ret) r_mem[r_wr_ptr] <= {r_sr_sop[RD_LATENCY-1], r_sr_eop[RD_LATENCY-1], rd_data};
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_rptr   <= '0;
      r_blocks <= '0;
    end else begin
      if (!enable_sfp)  r_rptr <= '0;
      else if (w_pop)   r_rptr <= r_rptr + W'(2);
      if (w_pop && dout_eop) r_blocks <= r_blocks + 32'd1;
    end
  end

`ifdef SONIC_RX_FETCH_OVERRUN_EN
  localparam logic [W-1:0] LAP_LIM = {{(W-1){1'b1}}, 1'b0};
  logic         r_overrun;
  logic [W-1:0] w_lag;

  assign w_lag   = rx_ring_wptr - r_rptr;
  assign overrun = r_overrun;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn)                r_overrun <= 1'b0;
    else if (!enable_sfp)     r_overrun <= 1'b0;
    else if (w_lag >= LAP_LIM) r_overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sonic_rx_dma_fetch.sv
// Bench for sonic_rx_dma_fetch: a W=16 instance against a block/stream reference model with
// random backpressure, plus a W=4 instance for the wrap and overrun corners.
module tb_sonic_rx_dma_fetch;
  logic         clk_in = 1'b0;
  logic         rstn;
  logic         enable_sfp;
  logic [15:0]  rx_ring_wptr;
  logic [31:0]  rx_block_size;
  logic         rd_req;
  logic [14:0]  rd_address_owords;
  logic [127:0] rd_data;
  logic         dout_valid, dout_ready, dout_sop, dout_eop;
  logic [127:0] dout_data;
  logic [15:0]  rx_ring_rptr;
  logic [31:0]  blocks_done;
  logic         overrun;

  logic         a_enable;
  logic [3:0]   a_wptr;
  logic [31:0]  a_bs;
  logic         a_rd_req;
  logic [2:0]   a_addr;
  logic [127:0] a_rd_data;
  logic         a_valid, a_ready, a_sop, a_eop;
  logic [127:0] a_data;
  logic [3:0]   a_rptr;
  logic [31:0]  a_blocks;
  logic         a_ovr;

`ifdef SONIC_RX_FETCH_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  sonic_rx_dma_fetch #(.USED_QWORDS_WIDTH(16), .RD_LATENCY(2), .FIFO_DEPTH(8)) dut (
    .clk_in(clk_in), .rstn(rstn), .enable_sfp(enable_sfp), .rx_ring_wptr(rx_ring_wptr),
    .rx_block_size(rx_block_size), .rd_req(rd_req), .rd_address_owords(rd_address_owords),
    .rd_data(rd_data), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .rx_ring_rptr(rx_ring_rptr),
    .blocks_done(blocks_done), .overrun(overrun));

  sonic_rx_dma_fetch #(.USED_QWORDS_WIDTH(4), .RD_LATENCY(2), .FIFO_DEPTH(8)) dut_w4 (
    .clk_in(clk_in), .rstn(rstn), .enable_sfp(a_enable), .rx_ring_wptr(a_wptr),
    .rx_block_size(a_bs), .rd_req(a_rd_req), .rd_address_owords(a_addr),
    .rd_data(a_rd_data), .dout_valid(a_valid), .dout_ready(a_ready), .dout_data(a_data),
    .dout_sop(a_sop), .dout_eop(a_eop), .rx_ring_rptr(a_rptr),
    .blocks_done(a_blocks), .overrun(a_ovr));

  function automatic logic [127:0] data_of(input logic [31:0] a);
    return {a * 32'h9E3779B1, ~a, a ^ 32'h5A5A5A5A, a + 32'h1000_0000};
  endfunction

  // Ring buffer model: data for an oword address appears two cycles after the read.
  logic [14:0] ap0, ap1;
  logic [2:0]  a_ap0, a_ap1;
  always @(posedge clk_in) begin
    ap1   <= ap0;
    ap0   <= rd_address_owords;
    a_ap1 <= a_ap0;
    a_ap0 <= a_addr;
  end
  assign rd_data   = data_of(32'(ap1));
  assign a_rd_data = data_of(32'(a_ap1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: issue side and output side of the block stream.
  int          m_iss_oaddr, m_iss_idx, m_iss_bs;
  int          m_out_oaddr, m_out_idx, m_out_bs;
  int          bsq[$];
  logic [15:0] m_rptr;
  logic [31:0] m_blocks;
  int          m_issued, m_accepted;
  logic        m_ovr;
  int          n_req, cyc_no, first_req_cyc, last_req_cyc;
  logic        prev_stall;
  logic [127:0] prev_data;

  task cyc();
    #1;
    chk("rptr", rx_ring_rptr, m_rptr);
    chk("blocks_done", blocks_done, m_blocks);
    chk("overrun", overrun, m_ovr);
    if (prev_stall && enable_sfp) begin
      chk("hold_valid", dout_valid, 1'b1);
      chk("hold_data", dout_data, prev_data);
    end
    if (!enable_sfp) chk("req_when_disabled", rd_req, 1'b0);
    if (rd_req) begin
      chk("credit", (m_issued - m_accepted) < 8, 1'b1);
      chk("rd_addr", rd_address_owords, m_iss_oaddr);
      if (m_iss_idx == 0) begin
        m_iss_bs = int'(rx_block_size[16:1]);
        chk("avail_at_start", ((int'(rx_ring_wptr) - 2*m_iss_oaddr) & 32'hffff) >= 2*m_iss_bs, 1'b1);
        bsq.push_back(m_iss_bs);
      end
      m_iss_idx++;
      if (m_iss_idx >= m_iss_bs) m_iss_idx = 0;
      m_iss_oaddr = (m_iss_oaddr + 1) & 32'h7fff;
      m_issued++;
      if (n_req == 0) first_req_cyc = cyc_no;
      last_req_cyc = cyc_no;
      n_req++;
    end
`ifdef SONIC_RX_FETCH_OVERRUN_EN
    if (enable_sfp && (((int'(rx_ring_wptr) - int'(m_rptr)) & 32'hffff) >= 65534)) m_ovr = 1'b1;
`endif
    if (dout_valid && dout_ready) begin
      if (m_out_idx == 0) begin
        if (bsq.size() == 0) begin
          chk("spurious_output", dout_valid, 1'b0);
          m_out_bs = 1;
        end else m_out_bs = bsq.pop_front();
      end
      chk("dout_data", dout_data, data_of(32'(m_out_oaddr)));
      chk("dout_sop", dout_sop, m_out_idx == 0);
      chk("dout_eop", dout_eop, m_out_idx == m_out_bs - 1);
      m_out_oaddr = (m_out_oaddr + 1) & 32'h7fff;
      m_rptr = m_rptr + 16'd2;
      m_accepted++;
      if (m_out_idx == m_out_bs - 1) begin
        m_blocks++;
        m_out_idx = 0;
      end else m_out_idx++;
    end
    prev_stall = dout_valid && !dout_ready;
    prev_data  = dout_data;
    if (!enable_sfp) begin
      m_iss_oaddr = 0; m_iss_idx = 0; m_out_oaddr = 0; m_out_idx = 0;
      bsq.delete();
      m_rptr = '0; m_issued = 0; m_accepted = 0; m_ovr = 1'b0; prev_stall = 1'b0;
    end
    cyc_no++;
    @(negedge clk_in);
  endtask

  logic [2:0] a_addrs[$];
  task acyc();
    #1;
    if (a_rd_req) a_addrs.push_back(a_addr);
    @(negedge clk_in);
  endtask

  initial begin
    int k;
    int seg_bs[6];
    logic [15:0] exp_ptr, seg_q, seg_av;
    logic [2:0] exp_w4[4];
    seg_bs = '{4, 6, 10, 16, 2, 14};
    exp_w4 = '{3'd6, 3'd7, 3'd0, 3'd1};

    m_iss_oaddr = 0; m_iss_idx = 0; m_iss_bs = 0; m_out_oaddr = 0; m_out_idx = 0; m_out_bs = 0;
    m_rptr = '0; m_blocks = '0; m_issued = 0; m_accepted = 0; m_ovr = 1'b0;
    n_req = 0; cyc_no = 0; first_req_cyc = 0; last_req_cyc = 0; prev_stall = 1'b0; prev_data = '0;

    rstn = 1'b0; enable_sfp = 1'b0; rx_ring_wptr = '0; rx_block_size = '0; dout_ready = 1'b0;
    a_enable = 1'b0; a_wptr = '0; a_bs = '0; a_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_rd_addr", rd_address_owords, 15'd0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_data", dout_data, 128'd0);
    chk("rst_sop_eop", {dout_sop, dout_eop}, 2'b00);
    chk("rst_rptr", rx_ring_rptr, 16'd0);
    chk("rst_blocks", blocks_done, 32'd0);
    chk("rst_overrun", overrun, 1'b0);
    @(negedge clk_in);
    rstn = 1'b1;
    cyc();

    // Test 1: block only after 8 qwords are available.
    enable_sfp = 1'b1; rx_block_size = 32'd8; dout_ready = 1'b1; n_req = 0;
    for (int w = 0; w <= 6; w += 2) begin
      rx_ring_wptr = 16'(w);
      cyc(); cyc();
    end
    chk("t1_no_req_below_block", n_req, 0);
    rx_ring_wptr = 16'd8;
    repeat (20) cyc();
    chk("t1_nreq", n_req, 4);
    chk("t1_back_to_back", last_req_cyc - first_req_cyc, 3);
    chk("t1_rptr", rx_ring_rptr, 16'd8);
    chk("t1_blocks", blocks_done, 32'd1);

    // Test 4: disable after two reads, then a fresh block from address 0.
    rx_ring_wptr = 16'd16; n_req = 0;
    k = 0;
    while (k < 20 && n_req < 2) begin cyc(); k++; end
    chk("t4_two_reads", n_req, 2);
    enable_sfp = 1'b0; dout_ready = 1'b0; rx_ring_wptr = 16'd0;
    cyc();
    chk("t4_valid_dropped", dout_valid, 1'b0);
    chk("t4_rptr_cleared", rx_ring_rptr, 16'd0);
    chk("t4_blocks_held", blocks_done, 32'd1);
    cyc();
    enable_sfp = 1'b1; dout_ready = 1'b1; rx_ring_wptr = 16'd8; n_req = 0;
    repeat (20) cyc();
    chk("t4_nreq", n_req, 4);
    chk("t4_rptr", rx_ring_rptr, 16'd8);
    chk("t4_blocks", blocks_done, 32'd2);

    // Test 3: stalled output limits issue to the FIFO depth.
    rx_block_size = 32'd16; dout_ready = 1'b0; rx_ring_wptr = 16'd40; n_req = 0;
    repeat (25) cyc();
    chk("t3_issue_capped", n_req, 8);
    chk("t3_valid_stalled", dout_valid, 1'b1);
    dout_ready = 1'b1;
    k = 0;
    while (k < 80 && rx_ring_rptr !== 16'd40) begin cyc(); k++; end
    chk("t3_rptr", rx_ring_rptr, 16'd40);
    chk("t3_nreq", n_req, 16);
    chk("t3_blocks", blocks_done, 32'd4);

    // Test 5: zero block size never fetches; odd size rounds down.
    rx_block_size = 32'd0; rx_ring_wptr = 16'd140; n_req = 0;
    repeat (20) cyc();
    chk("t5_bs0_no_req", n_req, 0);
    rx_block_size = 32'd9;
    k = 0;
    while (k < 200 && rx_ring_rptr !== 16'd136) begin cyc(); k++; end
    repeat (10) cyc();
    chk("t5_rptr", rx_ring_rptr, 16'd136);
    chk("t5_blocks", blocks_done, 32'd16);
    chk("t5_nreq", n_req, 48);
    chk("t5_idle", dout_valid, 1'b0);
    exp_ptr = 16'd136;

    // Random writer pace and backpressure across several block sizes.
    for (int s = 0; s < 6; s++) begin
      rx_block_size = 32'(seg_bs[s]);
      for (int j = 0; j < 400; j++) begin
        if ($urandom_range(3) == 0) rx_ring_wptr = rx_ring_wptr + 16'($urandom_range(8));
        dout_ready = ($urandom_range(2) != 0);
        cyc();
      end
      dout_ready = 1'b1;
      seg_q  = 16'((seg_bs[s] / 2) * 2);
      seg_av = rx_ring_wptr - exp_ptr;
      exp_ptr = exp_ptr + (seg_av / seg_q) * seg_q;
      k = 0;
      while (k < 3000 && rx_ring_rptr !== exp_ptr) begin cyc(); k++; end
      chk("seg_rptr", rx_ring_rptr, exp_ptr);
      repeat (12) cyc();
      chk("seg_idle", dout_valid, 1'b0);
      chk("seg_rptr_stable", rx_ring_rptr, exp_ptr);
    end

    // Test 2 on the 4-bit ring: a block that wraps the oword address space.
    enable_sfp = 1'b0;
    a_enable = 1'b1; a_bs = 32'd12; a_ready = 1'b1; a_wptr = 4'd12;
    repeat (30) acyc();
    chk("w4_rptr_first", a_rptr, 4'd12);
    chk("w4_blocks_first", a_blocks, 32'd1);
    a_addrs.delete();
    a_bs = 32'd8; a_wptr = 4'd4;
    repeat (20) acyc();
    chk("w4_nreq", a_addrs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < a_addrs.size()) chk("w4_wrap_addr", a_addrs[i], exp_w4[i]);
    end
    chk("w4_rptr_wrapped", a_rptr, 4'd4);
    chk("w4_blocks", a_blocks, 32'd2);

    // Test 6: lap flag threshold, stickiness and clear on disable.
    a_enable = 1'b0;
    repeat (2) acyc();
    chk("w4_rptr_cleared", a_rptr, 4'd0);
    chk("w4_ovr_cleared", a_ovr, 1'b0);
    a_enable = 1'b1; a_bs = 32'd0; a_wptr = 4'd13;
    repeat (3) acyc();
    chk("w4_ovr_below", a_ovr, 1'b0);
    a_wptr = 4'd14;
    repeat (2) acyc();
    chk("w4_ovr_set", a_ovr, EXP_OVR);
    a_bs = 32'd8;
    repeat (20) acyc();
    chk("w4_rptr_drained", a_rptr, 4'd8);
    chk("w4_ovr_sticky", a_ovr, EXP_OVR);
    a_enable = 1'b0;
    repeat (2) acyc();
    chk("w4_ovr_off", a_ovr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
